// File: rtl/utim_pkg.sv
// Shared definitions for the prescaled timer block.
// Mode encodings and default build parameters.
package utim_pkg;

    typedef enum logic {
        UTIM_MODE_FREE     = 1'b0,
        UTIM_MODE_PERIODIC = 1'b1
    } utim_mode_e;

    localparam int UTIM_WIDTH_DEF = 64;
    localparam int UTIM_CH_DEF    = 4;
    localparam int UTIM_PRE_W_DEF = 8;
    localparam int UTIM_SEL_W     = 3;

endpackage

// File: rtl/utim_prescaler.sv
// Tick divider: counts 0..divisor while enabled, pulses tick on the last step.
// Held at zero while disabled or when a config write clears it.
module utim_prescaler
    import utim_pkg::*;
#(
    parameter int P_PRE_W = UTIM_PRE_W_DEF
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               clear_i,
    input  logic               enable_i,
    input  logic [P_PRE_W-1:0] divisor_i,
    output logic               tick_o
);

    logic [P_PRE_W-1:0] cnt_q;
    logic [P_PRE_W-1:0] cnt_d;

    assign tick_o = enable_i && (cnt_q == divisor_i);

    always_comb begin
        cnt_d = cnt_q + P_PRE_W'(1);
        if (clear_i || !enable_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/utim_prescaled_counter.sv
// Prescaled free-run/periodic counter with per-channel compare and sticky flags.
// Loads are only honoured while stopped; register writes see the pre-edge state.
module utim_prescaled_counter
    import utim_pkg::*;
#(
    parameter int P_WIDTH = UTIM_WIDTH_DEF,
    parameter int P_CH    = UTIM_CH_DEF,
    parameter int P_PRE_W = UTIM_PRE_W_DEF
) (
    input  logic                    iCLOCK,
    input  logic                    inRESET,
    input  logic                    iCONF_WRITE,
    input  logic                    iCONF_ENA,
    input  logic                    iCONF_MODE,
    input  logic [P_PRE_W-1:0]      iCONF_PRESCALE,
    input  logic                    iCOUNT_WRITE,
    input  logic [P_WIDTH/32-1:0]   inCOUNT_DQM,
    input  logic [P_WIDTH-1:0]      iCOUNT_COUNTER,
    input  logic                    iCMP_WRITE,
    input  logic [UTIM_SEL_W-1:0]   iCMP_SEL,
    input  logic                    iCMP_ENA,
    input  logic [P_WIDTH-1:0]      iCMP_VALUE,
    input  logic [P_CH-1:0]         iIRQ_CLEAR,
    output logic                    oWORKING,
    output logic [P_WIDTH-1:0]      oCOUNTER,
    output logic [P_CH-1:0]         oIRQ,
    output logic                    oIRQ_ANY
);

    localparam int LP_WORDS = P_WIDTH / 32;

    logic                           working_q, working_d;
    utim_mode_e                     mode_q, mode_d;
    logic [P_PRE_W-1:0]             prescale_q, prescale_d;
    logic [P_WIDTH-1:0]             counter_q, counter_d;
    logic [P_CH-1:0][P_WIDTH-1:0]   cmp_q, cmp_d;
    logic [P_CH-1:0]                en_q, en_d;
    logic [P_CH-1:0]                irq_q, irq_d;
    logic [P_CH-1:0]                match;
    logic                           tick;

    utim_prescaler #(
        .P_PRE_W   (P_PRE_W)
    ) u_prescaler (
        .iCLOCK    (iCLOCK),
        .inRESET   (inRESET),
        .clear_i   (iCONF_WRITE),
        .enable_i  (working_q),
        .divisor_i (prescale_q),
        .tick_o    (tick)
    );

    always_comb begin
        working_d  = working_q;
        mode_d     = mode_q;
        prescale_d = prescale_q;
        if (iCONF_WRITE) begin
            working_d  = iCONF_ENA;
            mode_d     = utim_mode_e'(iCONF_MODE);
            prescale_d = iCONF_PRESCALE;
        end
    end

    // Load and tick are exclusive: loads need stopped, ticks need running.
    always_comb begin
        counter_d = counter_q;
        if (iCOUNT_WRITE && !working_q) begin
            for (int k = 0; k < LP_WORDS; k++) begin
                if (!inCOUNT_DQM[k]) begin
                    counter_d[32*k +: 32] = iCOUNT_COUNTER[32*k +: 32];
                end
            end
        end else if (tick) begin
            if (mode_q == UTIM_MODE_PERIODIC && counter_q == cmp_q[0]) begin
                counter_d = '0;
            end else begin
                counter_d = counter_q + P_WIDTH'(1);
            end
        end
    end

    always_comb begin
        cmp_d = cmp_q;
        en_d  = en_q;
        match = '0;
        for (int i = 0; i < P_CH; i++) begin
            if (iCMP_WRITE && iCMP_SEL == UTIM_SEL_W'(i)) begin
                cmp_d[i] = iCMP_VALUE;
                en_d[i]  = iCMP_ENA;
            end
            match[i] = tick && en_q[i] && (counter_q == cmp_q[i]);
        end
        irq_d = (irq_q & ~iIRQ_CLEAR) | match;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            working_q  <= 1'b0;
            mode_q     <= UTIM_MODE_FREE;
            prescale_q <= '0;
            counter_q  <= '0;
            cmp_q      <= '0;
            en_q       <= '0;
            irq_q      <= '0;
        end else begin
            working_q  <= working_d;
            mode_q     <= mode_d;
            prescale_q <= prescale_d;
            counter_q  <= counter_d;
            cmp_q      <= cmp_d;
            en_q       <= en_d;
            irq_q      <= irq_d;
        end
    end

    assign oWORKING = working_q;
    assign oCOUNTER = counter_q;
    assign oIRQ     = irq_q;
    assign oIRQ_ANY = |irq_q;

endmodule

// File: tb/tb_utim_prescaled_counter.sv
// Directed bench: default 64-bit/4-channel build and a 32-bit/2-channel build
// driven in lockstep from shared stimulus.
module tb_utim_prescaled_counter;

    logic        clk;
    logic        rst_n;
    logic        conf_wr;
    logic        conf_ena;
    logic        conf_mode;
    logic [7:0]  conf_pre;
    logic        cnt_wr;
    logic [1:0]  dqm;
    logic [63:0] cnt_val;
    logic        cmp_wr;
    logic [2:0]  cmp_sel;
    logic        cmp_ena;
    logic [63:0] cmp_val;
    logic [3:0]  irq_clr;

    logic        work_a;
    logic [63:0] cnt_a;
    logic [3:0]  irq_a;
    logic        any_a;

    logic        work_b;
    logic [31:0] cnt_b;
    logic [1:0]  irq_b;
    logic        any_b;

    int errors = 0;
    int checks = 0;

    utim_prescaled_counter dut_a (
        .iCLOCK         (clk),
        .inRESET        (rst_n),
        .iCONF_WRITE    (conf_wr),
        .iCONF_ENA      (conf_ena),
        .iCONF_MODE     (conf_mode),
        .iCONF_PRESCALE (conf_pre),
        .iCOUNT_WRITE   (cnt_wr),
        .inCOUNT_DQM    (dqm),
        .iCOUNT_COUNTER (cnt_val),
        .iCMP_WRITE     (cmp_wr),
        .iCMP_SEL       (cmp_sel),
        .iCMP_ENA       (cmp_ena),
        .iCMP_VALUE     (cmp_val),
        .iIRQ_CLEAR     (irq_clr),
        .oWORKING       (work_a),
        .oCOUNTER       (cnt_a),
        .oIRQ           (irq_a),
        .oIRQ_ANY       (any_a)
    );

    utim_prescaled_counter #(
        .P_WIDTH (32),
        .P_CH    (2)
    ) dut_b (
        .iCLOCK         (clk),
        .inRESET        (rst_n),
        .iCONF_WRITE    (conf_wr),
        .iCONF_ENA      (conf_ena),
        .iCONF_MODE     (conf_mode),
        .iCONF_PRESCALE (conf_pre),
        .iCOUNT_WRITE   (cnt_wr),
        .inCOUNT_DQM    (dqm[0]),
        .iCOUNT_COUNTER (cnt_val[31:0]),
        .iCMP_WRITE     (cmp_wr),
        .iCMP_SEL       (cmp_sel),
        .iCMP_ENA       (cmp_ena),
        .iCMP_VALUE     (cmp_val[31:0]),
        .iIRQ_CLEAR     (irq_clr[1:0]),
        .oWORKING       (work_b),
        .oCOUNTER       (cnt_b),
        .oIRQ           (irq_b),
        .oIRQ_ANY       (any_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic conf(input logic ena, input logic mode, input logic [7:0] pre);
        conf_wr   = 1'b1;
        conf_ena  = ena;
        conf_mode = mode;
        conf_pre  = pre;
    endtask

    task automatic idle();
        conf_wr = 1'b0;
        cnt_wr  = 1'b0;
        cmp_wr  = 1'b0;
        irq_clr = '0;
        dqm     = 2'b11;
    endtask

    initial begin
        rst_n     = 1'b0;
        conf_ena  = 1'b0;
        conf_mode = 1'b0;
        conf_pre  = '0;
        cnt_val   = '0;
        cmp_sel   = '0;
        cmp_ena   = 1'b0;
        cmp_val   = '0;
        idle();
        #12;
        chk("rst_work_a", {63'd0, work_a}, 64'd0);
        chk("rst_cnt_a", cnt_a, 64'd0);
        chk("rst_irq_a", {60'd0, irq_a}, 64'd0);
        chk("rst_cnt_b", {32'd0, cnt_b}, 64'd0);
        rst_n = 1'b1;
        cyc();

        // Load all-ones while a starting config write coincides
        cnt_wr  = 1'b1;
        dqm     = 2'b00;
        cnt_val = '1;
        conf(1'b1, 1'b0, 8'd0);
        cyc();
        idle();
        chk("load_start_a", cnt_a, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("load_start_b", {32'd0, cnt_b}, 64'h0000_0000_FFFF_FFFF);
        chk("working_a", {63'd0, work_a}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("pre0_a", cnt_a, 64'(i));
            chk("pre0_b", {32'd0, cnt_b}, 64'(i));
        end

        // Stop: the edge that latches ENA=0 still sees the running state
        conf(1'b0, 1'b0, 8'd0);
        cyc();
        idle();
        chk("stop_cnt_a", cnt_a, 64'd3);
        chk("stop_work_a", {63'd0, work_a}, 64'd0);
        cyc();
        chk("frozen_a", cnt_a, 64'd3);

        // Divide by four
        conf(1'b1, 1'b0, 8'd3);
        cyc();
        idle();
        chk("pre3_start", cnt_a, 64'd3);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk("pre3_a", cnt_a, 64'(3 + i / 4));
            chk("pre3_b", {32'd0, cnt_b}, 64'(3 + i / 4));
        end

        // Load while running is ignored
        cnt_wr  = 1'b1;
        dqm     = 2'b00;
        cnt_val = 64'h1234;
        cyc();
        idle();
        chk("run_load_a", cnt_a, 64'd5);
        chk("run_load_b", {32'd0, cnt_b}, 64'd5);
        conf(1'b0, 1'b0, 8'd3);
        cyc();
        idle();
        chk("stop2_a", cnt_a, 64'd5);

        // Masked word load
        cnt_wr  = 1'b1;
        dqm     = 2'b00;
        cnt_val = 64'h1111_2222_3333_4444;
        cyc();
        cnt_wr  = 1'b1;
        dqm     = 2'b10;
        cnt_val = 64'hAAAA_BBBB_CCCC_DDDD;
        cyc();
        idle();
        chk("dqm_a", cnt_a, 64'h1111_2222_CCCC_DDDD);
        chk("dqm_b", {32'd0, cnt_b}, 64'h0000_0000_CCCC_DDDD);

        // Periodic reload on channel 0 at 5
        cnt_wr  = 1'b1;
        dqm     = 2'b00;
        cnt_val = '0;
        cmp_wr  = 1'b1;
        cmp_sel = 3'd0;
        cmp_ena = 1'b1;
        cmp_val = 64'd5;
        cyc();
        idle();
        conf(1'b1, 1'b1, 8'd0);
        cyc();
        idle();
        chk("per_start", cnt_a, 64'd0);
        for (int i = 1; i <= 11; i++) begin
            cyc();
            chk("per_a", cnt_a, 64'(i % 6));
            chk("per_b", {32'd0, cnt_b}, 64'(i % 6));
            chk("per_irq_a", {60'd0, irq_a}, (i >= 6) ? 64'd1 : 64'd0);
            chk("per_any_b", {63'd0, any_b}, (i >= 6) ? 64'd1 : 64'd0);
        end
        irq_clr = 4'b0001;
        cyc();
        chk("clr_vs_set_cnt", cnt_a, 64'd0);
        chk("clr_vs_set_a", {60'd0, irq_a}, 64'd1);
        chk("clr_vs_set_b", {62'd0, irq_b}, 64'd1);
        cyc();
        idle();
        chk("clr_a", {60'd0, irq_a}, 64'd0);
        chk("clr_any_a", {63'd0, any_a}, 64'd0);
        chk("clr_b", {62'd0, irq_b}, 64'd0);

        // Out-of-range channel select on the 2-channel build
        conf(1'b0, 1'b0, 8'd0);
        cyc();
        idle();
        cnt_wr  = 1'b1;
        dqm     = 2'b00;
        cnt_val = '0;
        cmp_wr  = 1'b1;
        cmp_sel = 3'd3;
        cmp_ena = 1'b1;
        cmp_val = 64'd2;
        cyc();
        idle();
        conf(1'b1, 1'b0, 8'd0);
        cyc();
        idle();
        cyc();
        cyc();
        cyc();
        chk("sel3_cnt_b", {32'd0, cnt_b}, 64'd3);
        chk("sel3_irq_a", {60'd0, irq_a}, 64'h8);
        chk("sel3_irq_b", {62'd0, irq_b}, 64'd0);
        chk("sel3_any_b", {63'd0, any_b}, 64'd0);

        // Asynchronous reset mid-count
        rst_n = 1'b0;
        #1;
        chk("arst_cnt_a", cnt_a, 64'd0);
        chk("arst_irq_a", {60'd0, irq_a}, 64'd0);
        chk("arst_any_a", {63'd0, any_a}, 64'd0);
        chk("arst_work_a", {63'd0, work_a}, 64'd0);
        chk("arst_cnt_b", {32'd0, cnt_b}, 64'd0);
        chk("arst_work_b", {63'd0, work_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        conf(1'b1, 1'b0, 8'd0);
        cyc();
        idle();
        chk("post_rst_work_a", {63'd0, work_a}, 64'd1);
        chk("post_rst_work_b", {63'd0, work_b}, 64'd1);
        cyc();
        cyc();
        cyc();
        chk("post_rst_cnt_a", cnt_a, 64'd3);
        chk("post_rst_irq_a", {60'd0, irq_a}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
